// File: rtl/sumador_serial_ctrl.sv
// Bit-serial adder/subtractor: one full adder, one result bit per clock,
// LSB first, under a three-state IDLE/SUMA/FIN controller.

module SumadorCompleto (
  input  logic Cin,
  input  logic A,
  input  logic B,
  output logic St,
  output logic Cout
);

  assign St   = A ^ B ^ Cin;
  assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

module sumador_serial_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             resta,
  output logic [WIDTH-1:0] St,
  output logic             Cout,
  output logic             V,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SUMA,
    FIN
  } state_t;

  state_t state;
  state_t nstate;

  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] res;
  logic [CW-1:0]    cnt;
  logic             creg;

  logic             load;
  logic             step;
  logic             last;

  logic             fa_st;
  logic             fa_cout;

  assign last = (cnt == LAST);

  SumadorCompleto u_fa (
    .Cin  (creg),
    .A    (opa[0]),
    .B    (opb[0]),
    .St   (fa_st),
    .Cout (fa_cout)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= nstate;
    end
  end

  always_comb begin
    nstate = state;
    load   = 1'b0;
    step   = 1'b0;
    busy   = 1'b0;
    done   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          load   = 1'b1;
          nstate = SUMA;
        end
      end
      SUMA: begin
        busy = 1'b1;
        step = 1'b1;
        if (last) begin
          nstate = FIN;
        end
      end
      FIN: begin
        done = 1'b1;
        if (start) begin
          load   = 1'b1;
          nstate = SUMA;
        end else begin
          nstate = IDLE;
        end
      end
      default: begin
        nstate = IDLE;
      end
    endcase
  end

  // Subtraction is A + ~B + 1: invert B on load and seed the carry with 1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      opa  <= '0;
      opb  <= '0;
      res  <= '0;
      cnt  <= '0;
      creg <= 1'b0;
    end else if (load) begin
      opa  <= A;
      opb  <= resta ? ~B : B;
      creg <= resta ? 1'b1 : Cin;
      cnt  <= '0;
    end else if (step) begin
      opa  <= opa >> 1;
      opb  <= opb >> 1;
      res  <= {fa_st, res[WIDTH-1:1]};
      creg <= fa_cout;
      if (!last) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // On the last bit creg still holds the carry into the MSB.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      St   <= '0;
      Cout <= 1'b0;
      V    <= 1'b0;
    end else if (step && last) begin
      St   <= {fa_st, res[WIDTH-1:1]};
      Cout <= fa_cout;
      V    <= creg ^ fa_cout;
    end
  end

endmodule

// File: tb/tb_sumador_serial_ctrl.sv
// Directed bench for sumador_serial_ctrl (WIDTH=8) with a
// reference model for a strided operand sweep.

module tb_sumador_serial_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Cin;
  logic         resta;
  logic [W-1:0] St;
  logic         Cout;
  logic         V;
  logic         busy;
  logic         done;

  int tests;
  int fails;

  sumador_serial_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .Cin   (Cin),
    .resta (resta),
    .St    (St),
    .Cout  (Cout),
    .V     (V),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model(input  logic [W-1:0] a,
                       input  logic [W-1:0] b,
                       input  logic         ci,
                       input  logic         rs,
                       output logic [W-1:0] st,
                       output logic         co,
                       output logic         v);
    logic [W:0] s;
    if (rs) begin
      s  = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
      st = s[W-1:0];
      v  = (a[W-1] != b[W-1]) && (st[W-1] != a[W-1]);
    end else begin
      s  = {1'b0, a} + {1'b0, b} + (W+1)'(ci);
      st = s[W-1:0];
      v  = (a[W-1] == b[W-1]) && (st[W-1] != a[W-1]);
    end
    co = s[W];
  endtask

  // Called #1 after an edge; returns cycles from accept edge to done.
  task automatic run_op(input  logic [W-1:0] a,
                        input  logic [W-1:0] b,
                        input  logic         ci,
                        input  logic         rs,
                        output int           lat,
                        output int           nbusy);
    A     = a;
    B     = b;
    Cin   = ci;
    resta = rs;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat   = 0;
    nbusy = busy ? 1 : 0;
    for (int i = 1; i <= 3 * W; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = i;
        break;
      end
      if (busy) nbusy++;
    end
  endtask

  initial begin
    int lat;
    int nb;
    int dcount;
    int lastd;
    logic [W-1:0] est;
    logic eco;
    logic ev;

    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    start = 1'b1;
    A     = 8'h5A;
    B     = 8'h33;
    Cin   = 1'b0;
    resta = 1'b0;

    // start asserted during reset must be ignored
    repeat (2) @(posedge clk);
    #1;
    check("rst_St", 32'(St), 32'h0);
    check("rst_Cout", 32'(Cout), 32'h0);
    check("rst_V", 32'(V), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    start = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("idle_busy", 32'(busy), 32'h0);

    run_op(8'h5A, 8'h33, 1'b0, 1'b0, lat, nb);
    check("add1_lat", 32'(lat), 32'(W));
    check("add1_busy", 32'(nb), 32'(W));
    check("add1_St", 32'(St), 32'h8D);
    check("add1_Cout", 32'(Cout), 32'h0);
    check("add1_V", 32'(V), 32'h1);
    check("add1_nbusy", 32'(busy), 32'h0);

    run_op(8'hFF, 8'h01, 1'b0, 1'b0, lat, nb);
    check("add2_St", 32'(St), 32'h00);
    check("add2_Cout", 32'(Cout), 32'h1);
    check("add2_V", 32'(V), 32'h0);

    run_op(8'hFF, 8'h00, 1'b1, 1'b0, lat, nb);
    check("add3_St", 32'(St), 32'h00);
    check("add3_Cout", 32'(Cout), 32'h1);

    run_op(8'h10, 8'h01, 1'b1, 1'b1, lat, nb);
    check("sub1_St", 32'(St), 32'h0F);
    check("sub1_Cout", 32'(Cout), 32'h1);
    check("sub1_V", 32'(V), 32'h0);

    run_op(8'h01, 8'h02, 1'b0, 1'b1, lat, nb);
    check("sub2_St", 32'(St), 32'hFF);
    check("sub2_Cout", 32'(Cout), 32'h0);
    check("sub2_V", 32'(V), 32'h0);

    // outputs hold in IDLE
    repeat (3) @(posedge clk);
    #1;
    check("hold_idle_St", 32'(St), 32'hFF);
    check("hold_idle_done", 32'(done), 32'h0);

    // operand/start changes during SUMA must not matter
    A     = 8'h5A;
    B     = 8'h33;
    Cin   = 1'b0;
    resta = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    A     = 8'hFF;
    B     = 8'hFF;
    Cin   = 1'b1;
    resta = 1'b1;
    dcount = 0;
    for (int i = 1; i <= W; i++) begin
      start = (i < W - 1) ? ~start : 1'b0;
      @(posedge clk);
      #1;
      if (i == 3) check("hold_suma_St", 32'(St), 32'hFF);
      if (done) begin
        dcount++;
        check("mid_lat", 32'(i), 32'(W));
      end
    end
    check("mid_St", 32'(St), 32'h8D);
    check("mid_dones", 32'(dcount), 32'h1);
    dcount = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (done) dcount++;
    end
    check("mid_extra_dones", 32'(dcount), 32'h0);

    // start held high: back-to-back every W+1 cycles
    A     = 8'h01;
    B     = 8'h01;
    Cin   = 1'b0;
    resta = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    dcount = 0;
    lastd  = 0;
    for (int i = 1; i <= 4 * (W + 1); i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        dcount++;
        check("b2b_St", 32'(St), 32'h02);
        if (dcount == 1) check("b2b_first", 32'(i), 32'(W));
        else check("b2b_period", 32'(i - lastd), 32'(W + 1));
        lastd = i;
        if (dcount == 3) begin
          start = 1'b0;
          break;
        end
      end
    end
    check("b2b_count", 32'(dcount), 32'h3);
    repeat (2) @(posedge clk);
    #1;
    check("b2b_stop_busy", 32'(busy), 32'h0);

    // reset mid-operation discards it
    A     = 8'h5A;
    B     = 8'h33;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("pre_rst_busy", 32'(busy), 32'h1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("mrst_busy", 32'(busy), 32'h0);
    check("mrst_done", 32'(done), 32'h0);
    check("mrst_St", 32'(St), 32'h00);
    check("mrst_Cout", 32'(Cout), 32'h0);
    check("mrst_V", 32'(V), 32'h0);
    dcount = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (done) dcount++;
    end
    check("mrst_no_done", 32'(dcount), 32'h0);
    run_op(8'h03, 8'h04, 1'b0, 1'b0, lat, nb);
    check("mrst_new_lat", 32'(lat), 32'(W));
    check("mrst_new_St", 32'(St), 32'h07);

    // strided sweep against the reference model
    for (int a = 0; a < 256; a += 17) begin
      for (int b = 0; b < 256; b += 23) begin
        for (int m = 0; m < 4; m++) begin
          model(W'(a), W'(b), m[0], m[1], est, eco, ev);
          run_op(W'(a), W'(b), m[0], m[1], lat, nb);
          check($sformatf("sweep a=%0h b=%0h m=%0d", a, b, m),
                {22'h0, lat[0 +: 1], est, eco, ev},
                {22'h0, 1'b0, est, eco, ev});
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
